carry_look_ahead: RTL and testbench
===================================

# carry_look_ahead

Parameterizable N-bit two-level carry-lookahead adder with carry-in and carry-out. It serves as the fast adder inside the datapath ALU, for example for the add, sub and address paths of the single-cycle MIPS core. The sum and flags are produced combinationally. A registered copy of the result and flags is also provided for pipelined or debug consumers.

## Interface
Parameters:
- N, default 32: operand width. Must be a multiple of 4, from 4 to 64.

Ports:
- clk, input, 1: single clock. Rising edge updates the registered outputs only.
- reset, input, 1: asynchronous, active-high reset. Clears the registered outputs.
- A, input, N: operand A, unsigned or two's complement.
- B, input, N: operand B.
- C_in, input, 1: carry into bit 0.
- S, output, N: combinational sum, equal to (A + B + C_in) mod 2^N.
- C_out, output, 1: combinational carry out of bit N-1.
- V, output, 1: combinational signed overflow, equal to the carry into bit N-1 XOR C_out.
- S_q, output, N: registered S.
- C_out_q, output, 1: registered C_out.
- V_q, output, 1: registered V.
- Z_q, output, 1: registered zero flag, equal to (S == 0).

## Operation
- Per bit: g[i] = A[i] & B[i], p[i] = A[i] ^ B[i], S[i] = p[i] ^ c[i], with c[0] = C_in.
- Level 1: N/4 groups of 4 bits.
  - Each group computes internal carries by full lookahead, with no ripple inside the group.
  - Each group outputs a group generate GG and a group propagate GP.
  - GG = g3 | p3g2 | p3p2g1 | p3p2p1g0. GP = p3p2p1p0.
- Level 2: the carry into group k is computed by lookahead over GG and GP of groups 0..k-1 and C_in.
  - For N > 16, level 2 may be split into super-groups of 4 with a third lookahead level.
  - Carries must never ripple through more than 4 group-level stages.
- C_out is the carry out of the top group: GG_top | GP_top & c_in_top.
- Results must be bit-exact with A + B + C_in for all inputs.
- Boundary conditions:
  - All-ones plus 1 wraps S to 0 and sets C_out = 1.
  - C_in = 1 with A = ~B gives S = 0 and C_out = 1.
- The combinational outputs do not depend on clk or reset.

## Timing
- S, C_out and V have zero-cycle latency. They are purely combinational from A, B and C_in, with no latches.
- S_q, C_out_q, V_q and Z_q capture S, C_out, V and (S == 0) on each rising clk edge. Latency is 1 cycle and there is no enable.
- While reset is high, all registered outputs are forced to 0 immediately, without waiting for a clock edge. This applies to both S_q and Z_q.
- After reset deasserts, the first rising edge loads the current result.
- If reset asserts in the middle of a cycle, registered values are lost. The combinational outputs are unaffected.
- Critical path: one 4-bit lookahead, then the group lookahead, then the sum XOR. The path must not scale linearly with N.

## Structure
- Sub-module cla_4bit:
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], gg, gp.
  - Instantiated N/4 times through a generate loop.
- The group lookahead logic and the output registers live in carry_look_ahead.
- A shared package holds:
  - CLA_GROUP_W = 4.
  - The legal-N check as a helper function.
  - An elaboration-time assertion that N % 4 == 0.

## Test plan
- A=00000001, B=00000001, C_in=0 -> S=00000002, C_out=0, V=0.
- A=00000001, B=00000001, C_in=1 -> S=00000003, C_out=0.
- A=FFFFFFFF, B=00000001, C_in=0 -> S=00000000, C_out=1, V=0. One edge later Z_q=1.
- A=FFFF0000, B=0000FFFF, C_in=1 -> S=00000000, C_out=1. Also A=0F0F0F0F, B=F0F0F0F0, C_in=1 -> S=00000000, C_out=1.
- A=12345678, B=87654321, C_in=0 -> S=99999999, C_out=0, V=0. Also A=7FFFFFFF, B=00000001 -> S=80000000, V=1, C_out=0.
- Reset and random checks:
  - Assert reset between clock edges -> S_q, C_out_q, V_q and Z_q go to 0 immediately.
  - After release plus one edge, the registered outputs equal the combinational outputs.
  - 10k random A, B and C_in vectors -> {C_out,S} == A+B+C_in, for N=32 and N=8.

Source files
------------

// File: rtl/carry_look_ahead_pkg.sv
// Shared constants and lookahead helpers for the two-level carry-lookahead adder.
// The carry function is reused at bit, group and super-group level.
package carry_look_ahead_pkg;

    localparam int CLA_GROUP_W = 4;
    localparam int CLA_MIN_W   = 4;
    localparam int CLA_MAX_W   = 64;

    // Legal operand widths: multiples of the group width within the supported range.
    function automatic logic cla_n_legal(input int n);
        return (n >= CLA_MIN_W) && (n <= CLA_MAX_W) && ((n % CLA_GROUP_W) == 0);
    endfunction

    // Carry into position k (0..4) of a 4-wide block, built as a flat sum of
    // products over g/p and the block carry-in so nothing ripples.
    function automatic logic cla_carry(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       cin,
        input int         k
    );
        logic c;
        logic term;
        c = 1'b0;
        for (int m = 0; m < 4; m++) begin
            if (m < k) begin
                term = g[m];
                for (int t = m + 1; t < 4; t++) begin
                    if (t < k) begin
                        term = term & p[t];
                    end
                end
                c = c | term;
            end
        end
        term = cin;
        for (int t = 0; t < 4; t++) begin
            if (t < k) begin
                term = term & p[t];
            end
        end
        c = c | term;
        return c;
    endfunction

endpackage

// File: rtl/carry_look_ahead_cla_4bit.sv
// 4-bit lookahead block: sum bits from fully looked-ahead internal carries,
// plus group generate/propagate for the next lookahead level.
module cla_4bit
    import carry_look_ahead_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       gg,
    output logic       gp
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bit
            assign c[gi] = cla_carry(g, p, cin, gi);
            assign s[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    assign gg = cla_carry(g, p, 1'b0, 4);
    assign gp = &p;

endmodule

// File: rtl/carry_look_ahead.sv
// N-bit carry-lookahead adder: 4-bit blocks, group lookahead inside super-groups
// of four, and a super-group lookahead on top; plus registered result and flags.
module carry_look_ahead
    import carry_look_ahead_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         C_in,
    output logic [N-1:0] S,
    output logic         C_out,
    output logic         V,
    output logic [N-1:0] S_q,
    output logic         C_out_q,
    output logic         V_q,
    output logic         Z_q
);

    localparam int NG  = N / CLA_GROUP_W;
    localparam int NS  = (NG + 3) / 4;
    localparam int NGP = NS * 4;

    generate
        if (!cla_n_legal(N)) begin : g_bad_n
            $error("carry_look_ahead: N=%0d must be a multiple of 4 in 4..64", N);
        end
    endgenerate

    logic [NGP-1:0] gg;
    logic [NGP-1:0] gp;
    logic [NG-1:0]  group_cin;
    logic [3:0]     sgg;
    logic [3:0]     sgp;
    logic [NS-1:0]  super_cin;
    logic           carry_into_msb;

    genvar gi;
    generate
        // Level 1: one lookahead block per nibble; padded slots look like kill groups.
        for (gi = 0; gi < NGP; gi++) begin : g_group
            if (gi < NG) begin : g_real
                cla_4bit u_cla (
                    .a   (A[CLA_GROUP_W*gi +: CLA_GROUP_W]),
                    .b   (B[CLA_GROUP_W*gi +: CLA_GROUP_W]),
                    .cin (group_cin[gi]),
                    .s   (S[CLA_GROUP_W*gi +: CLA_GROUP_W]),
                    .gg  (gg[gi]),
                    .gp  (gp[gi])
                );
            end else begin : g_pad
                assign gg[gi] = 1'b0;
                assign gp[gi] = 1'b0;
            end
        end

        // Level 2 summary: generate/propagate of each super-group of four groups.
        for (gi = 0; gi < 4; gi++) begin : g_super_gp
            if (gi < NS) begin : g_real
                assign sgg[gi] = cla_carry(gg[4*gi +: 4], gp[4*gi +: 4], 1'b0, 4);
                assign sgp[gi] = &gp[4*gi +: 4];
            end else begin : g_pad
                assign sgg[gi] = 1'b0;
                assign sgp[gi] = 1'b0;
            end
        end

        // Level 3: carry into each super-group straight from C_in.
        for (gi = 0; gi < NS; gi++) begin : g_super_cin
            assign super_cin[gi] = cla_carry(sgg, sgp, C_in, gi);
        end

        // Level 2: carry into each group from its super-group carry-in.
        for (gi = 0; gi < NG; gi++) begin : g_group_cin
            assign group_cin[gi] = cla_carry(gg[4*(gi/4) +: 4], gp[4*(gi/4) +: 4],
                                             super_cin[gi/4], gi % 4);
        end
    endgenerate

    assign C_out = gg[NG-1] | (gp[NG-1] & group_cin[NG-1]);

    // The MSB sum bit is p ^ c, so the carry into the MSB is recovered without extra lookahead.
    assign carry_into_msb = S[N-1] ^ A[N-1] ^ B[N-1];
    assign V              = carry_into_msb ^ C_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            S_q     <= '0;
            C_out_q <= 1'b0;
            V_q     <= 1'b0;
            Z_q     <= 1'b0;
        end else begin
            S_q     <= S;
            C_out_q <= C_out;
            V_q     <= V;
            Z_q     <= (S == '0);
        end
    end

endmodule

// File: tb/tb_carry_look_ahead.sv
// Directed and random checks of the carry-lookahead adder at N=32 and N=8,
// including asynchronous reset behaviour of the registered outputs.
module tb_carry_look_ahead;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a, b, s, s_q;
    logic        cin, c_out, v, c_out_q, v_q, z_q;
    logic [7:0]  a8, b8, s8, s8_q;
    logic        cin8, c8_out, v8, c8_out_q, v8_q, z8_q;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    carry_look_ahead #(.N(32)) dut32 (
        .clk(clk), .reset(reset), .A(a), .B(b), .C_in(cin),
        .S(s), .C_out(c_out), .V(v),
        .S_q(s_q), .C_out_q(c_out_q), .V_q(v_q), .Z_q(z_q)
    );

    carry_look_ahead #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .A(a8), .B(b8), .C_in(cin8),
        .S(s8), .C_out(c8_out), .V(v8),
        .S_q(s8_q), .C_out_q(c8_out_q), .V_q(v8_q), .Z_q(z8_q)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Applies a 32-bit vector on the falling edge and checks the combinational outputs.
    task automatic vec32(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic tc, input logic [31:0] es, input logic ec, input logic ev);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc;
        #1;
        $display("vec %s: A=%h B=%h Cin=%0d -> S=%h Cout=%0d V=%0d", tag, ta, tb_v, tc, s, c_out, v);
        check({tag, ".S"}, 64'(s), 64'(es));
        check({tag, ".C_out"}, 64'(c_out), 64'(ec));
        check({tag, ".V"}, 64'(v), 64'(ev));
    endtask

    task automatic regs32(input string tag, input logic [31:0] es, input logic ec,
                          input logic ev, input logic ez);
        @(posedge clk);
        #1;
        $display("reg %s: S_q=%h C_out_q=%0d V_q=%0d Z_q=%0d", tag, s_q, c_out_q, v_q, z_q);
        check({tag, ".S_q"}, 64'(s_q), 64'(es));
        check({tag, ".C_out_q"}, 64'(c_out_q), 64'(ec));
        check({tag, ".V_q"}, 64'(v_q), 64'(ev));
        check({tag, ".Z_q"}, 64'(z_q), 64'(ez));
    endtask

    initial begin
        logic [32:0] exp33;
        logic [8:0]  exp9;
        logic        expv;

        reset = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0;

        // Reset asserted before any clock edge must clear registers at once.
        #2 reset = 1'b1;
        #1;
        $display("reset: S_q=%h C_out_q=%0d V_q=%0d Z_q=%0d", s_q, c_out_q, v_q, z_q);
        check("rst.S_q", 64'(s_q), 64'h0);
        check("rst.C_out_q", 64'(c_out_q), 64'h0);
        check("rst.V_q", 64'(v_q), 64'h0);
        check("rst.Z_q", 64'(z_q), 64'h0);
        check("rst.S8_q", 64'(s8_q), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        vec32("one_one",   32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0);
        vec32("one_one_c", 32'h00000001, 32'h00000001, 1'b1, 32'h00000003, 1'b0, 1'b0);
        regs32("one_one_c", 32'h00000003, 1'b0, 1'b0, 1'b0);
        vec32("wrap",      32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
        regs32("wrap",     32'h00000000, 1'b1, 1'b0, 1'b1);
        vec32("half_inv",  32'hFFFF0000, 32'h0000FFFF, 1'b1, 32'h00000000, 1'b1, 1'b0);
        vec32("nib_inv",   32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 32'h00000000, 1'b1, 1'b0);
        vec32("mixed",     32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0);
        vec32("pos_ovf",   32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
        regs32("pos_ovf",  32'h80000000, 1'b0, 1'b1, 1'b0);
        vec32("neg_ovf",   32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
        vec32("grp_edge",  32'h0000FFFF, 32'h00000000, 1'b1, 32'h00010000, 1'b0, 1'b0);
        vec32("mixed2",    32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0);
        regs32("mixed2",   32'h99999999, 1'b0, 1'b0, 1'b0);

        // Reset mid-cycle: registers clear immediately, combinational path untouched.
        #3 reset = 1'b1;
        #1;
        $display("mid_reset: S_q=%h C_out_q=%0d V_q=%0d Z_q=%0d S=%h", s_q, c_out_q, v_q, z_q, s);
        check("mid_rst.S_q", 64'(s_q), 64'h0);
        check("mid_rst.C_out_q", 64'(c_out_q), 64'h0);
        check("mid_rst.V_q", 64'(v_q), 64'h0);
        check("mid_rst.Z_q", 64'(z_q), 64'h0);
        check("mid_rst.S", 64'(s), 64'h99999999);
        @(negedge clk);
        reset = 1'b0;
        regs32("post_rst", 32'h99999999, 1'b0, 1'b0, 1'b0);

        // 8-bit directed boundaries.
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
        #1;
        $display("vec8 wrap: S=%h Cout=%0d V=%0d", s8, c8_out, v8);
        check("w8.S", 64'(s8), 64'h00);
        check("w8.C_out", 64'(c8_out), 64'h1);
        @(posedge clk);
        #1;
        check("w8.Z_q", 64'(z8_q), 64'h1);
        @(negedge clk);
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
        #1;
        $display("vec8 ovf: S=%h Cout=%0d V=%0d", s8, c8_out, v8);
        check("o8.S", 64'(s8), 64'h80);
        check("o8.V", 64'(v8), 64'h1);
        check("o8.C_out", 64'(c8_out), 64'h0);

        // Random sweep for both widths against native addition.
        for (int i = 0; i < 10000; i++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom_range(1));
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(1));
            #1;
            exp33 = {1'b0, a} + {1'b0, b} + 33'(cin);
            expv  = (a[31] == b[31]) && (exp33[31] != a[31]);
            check("rnd32.sum", 64'({c_out, s}), 64'(exp33));
            check("rnd32.V", 64'(v), 64'(expv));
            exp9 = {1'b0, a8} + {1'b0, b8} + 9'(cin8);
            expv = (a8[7] == b8[7]) && (exp9[7] != a8[7]);
            check("rnd8.sum", 64'({c8_out, s8}), 64'(exp9));
            check("rnd8.V", 64'(v8), 64'(expv));
        end
        $display("random: 10000 vectors applied to N=32 and N=8");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
